// File: rtl/line_clear.sv
// line_clear: removes completely filled rows from a placed-brick board.
// It scans a private copy of the board bottom-up, compacts the surviving rows
// downward in place, and zero-fills the vacated top rows. It then publishes
// the new board, this pass's line count and row mask, and a saturating
// running total of cleared lines.
module line_clear #(
    parameter int WIDTH   = 10,
    parameter int HEIGHT  = 20,
    parameter int CELL_W  = 3,
    parameter int TOTAL_W = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [WIDTH*HEIGHT*CELL_W-1:0]    board_in,
    output logic                              busy,
    output logic                              done,
    output logic [WIDTH*HEIGHT*CELL_W-1:0]    board_out,
    output logic [$clog2(HEIGHT+1)-1:0]       lines_cleared,
    output logic [HEIGHT-1:0]                 clear_mask,
    output logic [TOTAL_W-1:0]                total_lines
);

    localparam int ROW_W   = WIDTH * CELL_W;
    localparam int BOARD_W = ROW_W * HEIGHT;
    localparam int CNT_W   = $clog2(HEIGHT + 1);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(HEIGHT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]         state_reg;
    logic [CNT_W-1:0]   r_reg;      // row being scanned
    logic [CNT_W-1:0]   w_reg;      // next destination row (always <= r_reg)
    logic [CNT_W-1:0]   k_reg;      // full rows found so far
    logic [HEIGHT-1:0]  mask_reg;   // full-row mask collected during SCAN
    logic [ROW_W-1:0]   work_reg [HEIGHT];

    logic [BOARD_W-1:0] board_out_reg;
    logic [CNT_W-1:0]   lines_reg;
    logic [HEIGHT-1:0]  clear_mask_reg;
    logic [TOTAL_W-1:0] total_reg;
    logic               done_reg;

    logic [ROW_W-1:0]   cur_row;
    logic [WIDTH-1:0]   cell_nz;
    logic               row_full;
    logic [CNT_W-1:0]   k_next;
    logic [HEIGHT-1:0]  mask_next;
    logic [BOARD_W-1:0] final_board;
    logic [TOTAL_W:0]   total_sum;
    logic [TOTAL_W-1:0] total_sat;

    // The row under the scan pointer, and whether every one of its cells is occupied
    assign cur_row = work_reg[r_reg];

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        assign cell_nz[gi] = |cur_row[gi*CELL_W +: CELL_W];
    end

    assign row_full = (state_reg == ST_SCAN) && (&cell_nz);

    // Count and mask including the row scanned this cycle, so the values
    // published on the edge that enters DONE already include the last row
    always_comb begin
        k_next    = k_reg;
        mask_next = mask_reg;
        if (row_full) begin
            k_next           = k_reg + CNT_W'(1);
            mask_next[r_reg] = 1'b1;
        end
    end

    // Board as it stands after this edge's write. Only a FILL write can change
    // stored contents on the DONE-entry edge; a SCAN write there is in place.
    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_final
        assign final_board[gi*ROW_W +: ROW_W] =
            ((state_reg == ST_FILL) && (w_reg == CNT_W'(gi))) ? '0 : work_reg[gi];
    end

    // Running total with saturation at the counter's all-ones value
    assign total_sum = {1'b0, total_reg} + {{(TOTAL_W + 1 - CNT_W){1'b0}}, k_next};
    assign total_sat = total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : total_sum[TOTAL_W-1:0];

    // Sequencing FSM, row pointers and published results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            r_reg          <= '0;
            w_reg          <= '0;
            k_reg          <= '0;
            mask_reg       <= '0;
            board_out_reg  <= '0;
            lines_reg      <= '0;
            clear_mask_reg <= '0;
            total_reg      <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        r_reg     <= '0;
                        w_reg     <= '0;
                        k_reg     <= '0;
                        mask_reg  <= '0;
                        state_reg <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    k_reg    <= k_next;
                    mask_reg <= mask_next;
                    if (!row_full) begin
                        w_reg <= w_reg + CNT_W'(1);
                    end
                    if (r_reg == LAST_ROW) begin
                        if (k_next != '0) begin
                            state_reg <= ST_FILL;
                        end else begin
                            state_reg      <= ST_DONE;
                            board_out_reg  <= final_board;
                            lines_reg      <= k_next;
                            clear_mask_reg <= mask_next;
                            total_reg      <= total_sat;
                            done_reg       <= 1'b1;
                        end
                    end else begin
                        r_reg <= r_reg + CNT_W'(1);
                    end
                end
                ST_FILL: begin
                    w_reg <= w_reg + CNT_W'(1);
                    if (w_reg == LAST_ROW) begin
                        state_reg      <= ST_DONE;
                        board_out_reg  <= final_board;
                        lines_reg      <= k_next;
                        clear_mask_reg <= mask_next;
                        total_reg      <= total_sat;
                        done_reg       <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Work buffer: snapshot on start, in-place compaction during SCAN, zero-fill during FILL
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HEIGHT; i++) begin
                work_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < HEIGHT; i++) begin
                            work_reg[i] <= board_in[i*ROW_W +: ROW_W];
                        end
                    end
                end
                ST_SCAN: begin
                    if (!row_full) begin
                        work_reg[w_reg] <= cur_row;
                    end
                end
                ST_FILL: begin
                    work_reg[w_reg] <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign board_out     = board_out_reg;
    assign lines_cleared = lines_reg;
    assign clear_mask    = clear_mask_reg;
    assign total_lines   = total_reg;

endmodule

// File: tb/tb_line_clear.sv
// Testbench for line_clear: directed boards from the test plan, random boards
// compared against a queue-based row-removal model, start/board_in disturbance
// during a pass, mid-pass reset, and saturation of the running total.
module tb_line_clear;

    localparam int W   = 10;
    localparam int H   = 20;
    localparam int CW  = 3;
    localparam int TW  = 8;   // narrow running total so saturation is reachable quickly
    localparam int RW  = W * CW;
    localparam int BW  = RW * H;
    localparam int LCW = $clog2(H + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [BW-1:0]  board_in;
    logic           busy;
    logic           done;
    logic [BW-1:0]  board_out;
    logic [LCW-1:0] lines_cleared;
    logic [H-1:0]   clear_mask;
    logic [TW-1:0]  total_lines;

    int checks   = 0;
    int failures = 0;

    logic [BW-1:0]  exp_board;
    int             exp_lines;
    logic [H-1:0]   exp_mask;
    int             exp_total;

    line_clear #(.WIDTH(W), .HEIGHT(H), .CELL_W(CW), .TOTAL_W(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .clear_mask    (clear_mask),
        .total_lines   (total_lines)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: keep non-full rows in bottom-up order, drop full ones, pad with empty rows
    task automatic model(input logic [BW-1:0] b);
        logic [RW-1:0] kept[$];
        logic [RW-1:0] row;
        bit full;
        kept.delete();
        exp_lines = 0;
        exp_mask  = '0;
        for (int y = 0; y < H; y++) begin
            row  = b[y*RW +: RW];
            full = 1'b1;
            for (int x = 0; x < W; x++) begin
                if (row[x*CW +: CW] == '0) full = 1'b0;
            end
            if (full) begin
                exp_lines++;
                exp_mask[y] = 1'b1;
            end else begin
                kept.push_back(row);
            end
        end
        exp_board = '0;
        for (int i = 0; i < kept.size(); i++) exp_board[i*RW +: RW] = kept[i];
    endtask

    function automatic logic [BW-1:0] put_cell(input logic [BW-1:0] b, input int x, input int y,
                                               input int v);
        logic [BW-1:0] t;
        t = b;
        t[(y*W + x)*CW +: CW] = CW'(v);
        return t;
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        int kind;
        b = '0;
        for (int y = 0; y < H; y++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                for (int x = 0; x < W; x++) b = put_cell(b, x, y, $urandom_range(1, 7));
            end else if (kind < 8) begin
                for (int x = 0; x < W; x++) b = put_cell(b, x, y, $urandom_range(0, 7));
                b = put_cell(b, $urandom_range(0, W - 1), y, 0);
            end
        end
        return b;
    endfunction

    // One complete pass; disturb re-asserts start in SCAN and DONE and alters board_in mid-pass
    task automatic run_pass(input logic [BW-1:0] b, input string tag, input bit disturb);
        int cyc;
        int extra;
        model(b);
        exp_total = exp_total + exp_lines;
        if (exp_total > (1 << TW) - 1) exp_total = (1 << TW) - 1;
        @(posedge clk); #1;
        board_in = b;
        start    = 1'b1;
        @(posedge clk); #1;    // E0 has sampled start
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy_hi"}, BW'(busy), BW'(1));
        while (done !== 1'b1 && cyc < 80) begin
            if (disturb && cyc == 3) board_in = ~b;
            if (disturb && cyc == 5) start = 1'b1;
            if (disturb && cyc == 6) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done"},    BW'(done), BW'(1));
        chk({tag, "_latency"}, BW'(cyc), BW'(H + 1 + exp_lines));
        chk({tag, "_board"},   board_out, exp_board);
        chk({tag, "_lines"},   BW'(lines_cleared), BW'(exp_lines));
        chk({tag, "_mask"},    BW'(clear_mask), BW'(exp_mask));
        chk({tag, "_total"},   BW'(total_lines), BW'(exp_total));
        $display("pass %s: cycles=%0d lines=%0d mask=%05h total=%0d", tag, cyc, lines_cleared,
                 clear_mask, total_lines);
        if (disturb) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_pulse"}, BW'(done), BW'(0));
        chk({tag, "_busy_lo"},    BW'(busy), BW'(0));
        if (disturb) begin
            extra = 0;
            repeat (30) begin
                @(posedge clk); #1;
                if (done === 1'b1) extra++;
            end
            chk({tag, "_extra_done"}, BW'(extra), BW'(0));
        end
    endtask

    logic [BW-1:0] b;
    int            nd;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        board_in  = '0;
        exp_total = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  BW'(busy), BW'(0));
        chk("rst_done",  BW'(done), BW'(0));
        chk("rst_board", board_out, '0);
        chk("rst_lines", BW'(lines_cleared), BW'(0));
        chk("rst_mask",  BW'(clear_mask), BW'(0));
        chk("rst_total", BW'(total_lines), BW'(0));
        rst = 1'b0;

        // Empty board
        run_pass('0, "empty", 1'b0);

        // Row 0 full of type 1, row 1 half filled with type 3
        b = '0;
        for (int x = 0; x < W; x++) b = put_cell(b, x, 0, 1);
        for (int x = 0; x < 5; x++) b = put_cell(b, x, 1, 3);
        run_pass(b, "one_line", 1'b0);
        chk("one_line_mask_lit", BW'(clear_mask), BW'(20'h00001));

        // Rows 0,1,3,5 full; rows 2 and 4 partial with distinct types
        b = '0;
        for (int x = 0; x < W; x++) begin
            b = put_cell(b, x, 0, 2);
            b = put_cell(b, x, 1, 4);
            b = put_cell(b, x, 3, 5);
            b = put_cell(b, x, 5, 6);
        end
        for (int x = 0; x < 3; x++) b = put_cell(b, x, 2, 3);
        for (int x = 5; x < W; x++) b = put_cell(b, x, 4, 7);
        run_pass(b, "four_lines", 1'b0);
        chk("four_lines_mask_lit", BW'(clear_mask), BW'(20'h0002B));

        // Whole board full
        b = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) b = put_cell(b, x, y, 1 + ((x + y) % 7));
        run_pass(b, "all_full", 1'b0);

        // Random boards
        for (int i = 0; i < 12; i++) run_pass(rand_board(), $sformatf("rand%0d", i), 1'b0);

        // start re-asserted in SCAN and DONE, board_in changed mid-pass
        run_pass(rand_board(), "disturb", 1'b1);

        // Reset during a pass
        @(posedge clk); #1;
        board_in = rand_board();
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_total = 0;
        chk("midrst_busy",  BW'(busy), BW'(0));
        chk("midrst_done",  BW'(done), BW'(0));
        chk("midrst_board", board_out, '0);
        chk("midrst_lines", BW'(lines_cleared), BW'(0));
        chk("midrst_mask",  BW'(clear_mask), BW'(0));
        chk("midrst_total", BW'(total_lines), BW'(0));
        nd = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        chk("midrst_no_done", BW'(nd), BW'(0));
        $display("mid-pass reset: done pulses afterwards=%0d", nd);
        run_pass(rand_board(), "after_rst", 1'b0);

        // Saturation of the running total
        b = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) b = put_cell(b, x, y, 7);
        for (int i = 0; i < 14; i++) run_pass(b, $sformatf("sat%0d", i), 1'b0);
        chk("sat_total_lit", BW'(total_lines), BW'((1 << TW) - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_clear.md
# line_clear

Row-clear engine for the Tetris playfield. It is the consumer of the placed-brick board: once a brick has been merged into the stored board, this block scans the board bottom-up and removes every completely filled row. It compacts the remaining rows downward, zero-fills the vacated top rows, and returns the new board plus per-pass and running line counts. It sits between the placement FSM (which pulses `start` after PLACE) and the board register that feeds display and collision checking.

## Interface
- `WIDTH`, 10: cells per row (x).
- `HEIGHT`, 20: rows (y); row 0 is the bottom.
- `CELL_W`, 3: bits per cell. Value 0 = empty; 1..7 = brick type.
- `TOTAL_W`, 16: width of running line counter.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `board_in` in WIDTH\*HEIGHT\*CELL_W: board snapshot; cell (x,y) at bits [(y\*WIDTH+x)\*CELL_W +: CELL_W].
- `busy` out 1: high in SCAN, FILL, DONE.
- `done` out 1: one-cycle pulse when result is valid.
- `board_out` out WIDTH\*HEIGHT\*CELL_W: compacted board, same layout; held between passes.
- `lines_cleared` out $clog2(HEIGHT+1): full rows removed in last pass.
- `clear_mask` out HEIGHT: bit y set if input row y was full in last pass (for flash effect).
- `total_lines` out TOTAL_W: saturating sum of all `lines_cleared` since reset.

## Operation
- States: IDLE, SCAN, FILL, DONE.
- IDLE: on `start`=1, copy `board_in` into internal work buffer. Set r=0, w=0, k=0, mask=0. Go to SCAN. `start`=0 keeps IDLE.
- SCAN: one row per cycle, r = 0..HEIGHT-1.
  - Row r is full iff all WIDTH cells are nonzero. If full: k++, mask[r]=1, w unchanged.
  - If not full: write row r to work row w (in place; w ≤ r always), w++.
  - After r=HEIGHT-1: go to FILL if k>0, else DONE.
- FILL: write zeros to work row w, w++, one row per cycle. After row HEIGHT-1 is written (k cycles), go to DONE.
- DONE: for one cycle, `done`=1. `board_out`, `lines_cleared`=k and `clear_mask`=mask are updated on entry. `total_lines` = min(total_lines+k, 2^TOTAL_W-1). Next state is IDLE.
- `start` in SCAN/FILL/DONE is ignored; it is not queued.
- `board_in` changes after the start edge do not affect the pass.
- Row with a mix of empty and filled cells is never cleared; empty rows are moved like any non-full row.
- Arithmetic: r, w, k are $clog2(HEIGHT+1) bits; no wrap is possible since k ≤ HEIGHT.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `board_out`=0, `lines_cleared`=0, `clear_mask`=0, `total_lines`=0. Work buffer and counters are cleared.
- `rst` mid-pass aborts immediately. Outputs take their reset values on the next edge, and no `done` is produced.
- Let E0 be the edge sampling `start`. `busy` goes high after E0.
  - Rows are scanned on E1..E(HEIGHT).
  - FILL runs on E(HEIGHT+1)..E(HEIGHT+k).
  - DONE is the cycle after E(HEIGHT+k).
  - `done` and new outputs are visible HEIGHT+k+1 cycles after E0 (21 for k=0 with defaults).
- `busy` drops after the DONE cycle. A new `start` is accepted on the first IDLE cycle (back-to-back period HEIGHT+k+2).
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Empty board, `start` → `done` exactly 21 cycles after E0; `board_out`=0, `lines_cleared`=0, `clear_mask`=0, `total_lines`=0.
- Row 0 all type 1; row 1 cells x=0..4 type 3, rest empty → after 22 cycles: row 0 = former row 1, rows 1..19 zero, `lines_cleared`=1, `clear_mask`=20'h00001.
- Rows 0,1,3,5 full; rows 2,4 partial (distinct types) → row 0 = old row 2, row 1 = old row 4, rows 2..19 zero, `lines_cleared`=4, `clear_mask`=20'h0002B, `total_lines`=4, `done` at 25 cycles.
- All 20 rows full → `board_out`=0, `lines_cleared`=20, mask=20'hFFFFF, `done` at 41 cycles. Repeat 3277 times with TOTAL_W=16: `total_lines` saturates at 65535.
- `start` re-asserted during SCAN and during DONE → ignored: exactly one `done`. `board_in` altered mid-pass → result reflects the snapshot.
- `rst` asserted at cycle 10 of a pass → all outputs zero next edge, no `done`. A fresh `start` afterwards completes normally.
